// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_4
//  Description : Four-requester round-robin arbiter with locking grants.
//                Produces a registered 2-bit grant index plus valid flag,
//                a grant-start pulse, and a saturating hold counter.
//                Optional hold limit is compiled in with RR_HOLD_LIMIT_EN:
//                a grant is revoked after MAX_HOLD cycles and 'expire'
//                pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4 #(
    parameter int CNT_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    output logic [1:0]       grant_idx,
    output logic             grant_valid,
    output logic             grant_start,
    output logic             expire,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic             r_start;
    logic             w_start_nxt;
    logic             r_expire;
    logic             w_expire_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [3:0]       w_holder_oh;
    logic             w_holder_req;
    logic             w_hold_hit;
    logic [1:0]       w_search_ptr;
    logic [3:0]       w_search_req;
    logic             w_win_found;
    logic [1:0]       w_win_idx;

    assign w_holder_oh  = 4'b0001 << r_idx;
    assign w_holder_req = |(req & w_holder_oh);

`ifdef RR_HOLD_LIMIT_EN
    localparam logic [CNT_W-1:0] c_MAX_HOLD = CNT_W'(MAX_HOLD);

    // Hold limit reached: the grant has been valid for MAX_HOLD cycles.
    assign w_hold_hit = (r_state == ST_GRANT) && (r_cnt == c_MAX_HOLD);
`else
    logic w_unused_max_hold;

    // No hold limit: a holder keeps the grant until it releases.
    assign w_hold_hit        = 1'b0;
    assign w_unused_max_hold = (MAX_HOLD == 0);
`endif

    // While granted, a new search always starts just after the holder and
    // never considers the holder itself; from IDLE it starts at the pointer.
    assign w_search_ptr = (r_state == ST_GRANT) ? (r_idx + 2'd1) : r_ptr;
    assign w_search_req = (r_state == ST_GRANT) ? (req & ~w_holder_oh) : req;

    // Round-robin search: first asserted request at ptr, ptr+1, ptr+2, ptr+3.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = w_search_ptr;
        // Walk from the farthest offset down so the nearest one wins last.
        for (int i = 3; i >= 0; i--) begin
            if (w_search_req[w_search_ptr + 2'(i)]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_search_ptr + 2'(i);
            end
        end
    end

    // Next-state and next-output computation for the grant FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_idx_nxt    = r_idx;
        w_start_nxt  = 1'b0;
        w_expire_nxt = 1'b0;
        w_cnt_nxt    = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = ST_GRANT;
                    w_idx_nxt   = w_win_idx;
                    w_start_nxt = 1'b1;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end

            ST_GRANT: begin
                if (!w_holder_req || w_hold_hit) begin
                    // Release or expiry: advance past the holder and re-arbitrate.
                    // A simultaneous release wins, so expire only fires when the
                    // holder is still requesting.
                    w_ptr_nxt    = r_idx + 2'd1;
                    w_expire_nxt = w_holder_req;
                    if (w_win_found) begin
                        w_idx_nxt   = w_win_idx;
                        w_start_nxt = 1'b1;
                        w_cnt_nxt   = c_CNT_ONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else if (r_cnt != c_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 2'd0;
            r_idx    <= 2'd0;
            r_start  <= 1'b0;
            r_expire <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_idx    <= w_idx_nxt;
            r_start  <= w_start_nxt;
            r_expire <= w_expire_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign grant_idx   = r_idx;
    assign grant_valid = (r_state == ST_GRANT);
    assign grant_start = r_start;
    assign expire      = r_expire;
    assign hold_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter with locking grants. It produces a registered 2-bit grant index plus a valid flag. The index feeds the 2-to-4 one-hot decoder directly downstream, which turns it into per-requester enables. Consumers must gate the decoded enables with `grant_valid`.

## Interface
Parameters:
- `CNT_W`, default 4: width of the hold counter.
- `MAX_HOLD`, default 8: maximum grant length in cycles when the hold limit is compiled in. Legal range is 1 to 2^CNT_W−1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req`  in  4: request vector, one bit per requester. Level-sensitive; a requester holds its bit for the whole transaction.
- `grant_idx`  out  2: index of the current or last grantee. Drives the downstream decoder select.
- `grant_valid`  out  1: `grant_idx` is an active grant.
- `grant_start`  out  1: 1-cycle pulse in the first cycle of every new grant, including handoffs.
- `expire`  out  1: 1-cycle pulse when a grant is revoked by the hold limit.
- `hold_cnt`  out  CNT_W: number of cycles the current grant has been valid. Equals 1 in the first cycle; saturates at 2^CNT_W−1.

## Operation
- States: IDLE (`grant_valid`=0) and GRANT (`grant_valid`=1).
- Internal pointer `ptr[1:0]`. Search order is ptr, ptr+1, ptr+2, ptr+3, all modulo 4. The first asserted `req` bit in that order wins.
- **IDLE, req≠0:** register winner into `grant_idx`, set `grant_valid`=1, `grant_start`=1, `hold_cnt`=1, go to GRANT.
- **IDLE, req=0:** hold all state; `grant_idx` keeps its last value.
- **GRANT, req[grant_idx]=1, no expiry:** stay in GRANT; `hold_cnt` increments, saturating.
- **GRANT, req[grant_idx]=0 (release):**
  - Set ptr = grant_idx+1.
  - Search the other requesters from ptr.
  - If a winner exists: hand off with no bubble. `grant_valid` stays 1, `grant_idx` takes the new winner, `grant_start`=1, `hold_cnt`=1.
  - If no winner: go to IDLE, `grant_valid`=0, `hold_cnt`=0.
- Wrap-around: after index 3, ptr=0.
- Simultaneous release and expiry on the same edge: treated as a release; `expire` stays 0.
- Reset values: `grant_idx`=0, `grant_valid`=0, `grant_start`=0, `expire`=0, `hold_cnt`=0, ptr=0, state IDLE. After reset, req[0] has first priority.
- Reset mid-grant: `rst` overrides every transition. Outputs reach reset values on the same edge; no `expire` or `grant_start` pulse is generated.

## Timing
- Request to grant: 1 cycle. `req` sampled at edge k gives `grant_valid`=1 after edge k.
- Release to next grant: 1 cycle. `req[grant_idx]` sampled low at edge k gives the new `grant_idx`, or `grant_valid`=0, after edge k.
- All outputs are registered; there is no combinational path from `req` to any output.
- `grant_start` and `expire` are high for exactly one cycle per event.

## Configuration
Macro: `RR_HOLD_LIMIT_EN`.

Defined:
- When in GRANT with the holder still requesting and `hold_cnt`==MAX_HOLD:
  - `expire`=1 for one cycle and ptr=grant_idx+1.
  - Arbitration on that edge excludes the current holder.
  - Another winner: hand off exactly as on release.
  - No other winner: go to IDLE for at least one cycle. The holder may be re-granted from IDLE.
- Expiry is evaluated on the edge at which `hold_cnt` is sampled equal to MAX_HOLD. A grant is therefore valid for exactly MAX_HOLD cycles.

Undefined:
- There is no hold limit; a holder keeps the grant until it releases.
- `expire` is tied to 0.
- `MAX_HOLD` is unused.

## Test plan
1. Reset, then `req`=0100 → 1 cycle later `grant_valid`=1, `grant_idx`=2, `grant_start` pulses once, `hold_cnt`=1,2,3…
2. `req`=1111, each holder drops its bit for 1 cycle after 2 grant cycles, then reasserts → `grant_idx` sequence 0,1,2,3,0 with `grant_valid` continuously 1 and one `grant_start` per handoff.
3. `req`=0001 for 3 cycles then 0000 → `grant_valid` falls 1 cycle after release with `grant_idx` held at 0. Then `req`=0011 → grant to 1 (ptr=1).
4. `RR_HOLD_LIMIT_EN` defined, MAX_HOLD=4, `req`=0011 held:
   - Grants 0 for 4 cycles, `expire` pulses, grant 1 for 4 cycles, `expire`, grant 0, and so on.
   - Repeat with the macro undefined: grant 0 indefinitely, `expire`=0.
5. Macro defined, MAX_HOLD=4, `req`=0001 held → 4 valid cycles, `expire` pulse, 1 IDLE cycle with `grant_valid`=0, then re-grant 0 with `grant_start`.
6. `rst` pulsed mid-grant of index 2 → next edge all outputs 0. Then `req`=1001 → grant 0 (ptr reset to 0).
